// File: rtl/if_fetch_queue.sv
// Fetch-stage queue: issues PCs to instruction SRAM, pairs in-order responses with PCs, buffers {pc, inst} for ID.
// Latency: data_ok -> out_valid 1 cycle (0 cycles when IFQ_BYPASS_EN is defined and the queue is empty).
// Backpressure: requests are credit-limited so every response has a slot; block_vec stalls both issue and delivery.

module ifq_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module if_fetch_queue #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 4,
    parameter int NBLK   = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       in_allowin,
    input  logic [NBLK-1:0]            block_vec,
    input  logic                       flush,
    output logic                       inst_sram_req,
    output logic [PC_W-1:0]            inst_sram_addr,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [DATA_W-1:0]          inst_sram_rdata,
    output logic                       out_valid,
    output logic [PC_W-1:0]            out_pc,
    output logic [DATA_W-1:0]          out_inst,
    input  logic                       out_allowin,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] inst;
    } ifq_ent_t;

    logic            blocked;
    logic            credit;
    logic [CW-1:0]   pend_cnt;
    logic [CW-1:0]   cancel_cnt;
    logic [PC_W-1:0] pend_head;
    logic            drop;
    logic            q_vld;
    logic            q_push;
    logic            q_pop;
    logic            byp_take;
    ifq_ent_t        q_in;
    ifq_ent_t        q_head;

    assign blocked = |block_vec;
    assign credit  = ({1'b0, pend_cnt} + {1'b0, q_count}) < (CW+1)'(DEPTH);

    assign inst_sram_req  = in_valid & credit & ~blocked & ~flush;
    assign inst_sram_addr = in_pc;
    assign in_allowin     = inst_sram_req & inst_sram_addr_ok;

    ifq_fifo #(.W(PC_W), .DEPTH(DEPTH)) u_pend_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (1'b0),
        .push     (in_allowin),
        .push_dat (in_pc),
        .pop      (inst_sram_data_ok),
        .head_dat (pend_head),
        .count    (pend_cnt)
    );

    // Every response still in flight at flush time belongs to a discarded fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            cancel_cnt <= '0;
        end else if (flush) begin
            cancel_cnt <= pend_cnt - CW'(inst_sram_data_ok);
        end else if (inst_sram_data_ok && cancel_cnt != '0) begin
            cancel_cnt <= cancel_cnt - CW'(1);
        end
    end

    assign drop  = flush | (cancel_cnt != '0);
    assign q_vld = (q_count != '0) & ~blocked & ~flush;
    assign q_in  = '{pc: pend_head, inst: inst_sram_rdata};

`ifdef IFQ_BYPASS_EN
    logic byp_vld;
    assign byp_vld   = inst_sram_data_ok & (q_count == '0) & ~drop & ~blocked;
    assign byp_take  = byp_vld & out_allowin;
    assign out_valid = q_vld | byp_vld;
    assign out_pc    = (q_count != '0) ? q_head.pc   : pend_head;
    assign out_inst  = (q_count != '0) ? q_head.inst : inst_sram_rdata;
`else
    assign byp_take  = 1'b0;
    assign out_valid = q_vld;
    assign out_pc    = q_head.pc;
    assign out_inst  = q_head.inst;
`endif

    assign q_push = inst_sram_data_ok & ~drop & ~byp_take;
    assign q_pop  = q_vld & out_allowin;

    ifq_fifo #(.W($bits(ifq_ent_t)), .DEPTH(DEPTH)) u_out_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .push     (q_push),
        .push_dat (q_in),
        .pop      (q_pop),
        .head_dat (q_head),
        .count    (q_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_no_spurious_data_ok: assert (!(inst_sram_data_ok && pend_cnt == '0));
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed vector bench for if_fetch_queue; one table row per clock cycle plus hand sequences.
module tb_if_fetch_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_pc;
    logic        in_allowin;
    logic [4:0]  block_vec;
    logic        flush;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_allowin;
    logic [2:0]  q_count;

`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    if_fetch_queue dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_pc             (in_pc),
        .in_allowin        (in_allowin),
        .block_vec         (block_vec),
        .flush             (flush),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .out_valid         (out_valid),
        .out_pc            (out_pc),
        .out_inst          (out_inst),
        .out_allowin       (out_allowin),
        .q_count           (q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [4:0]  blk;
        logic        fl, aok, dok;
        logic [31:0] rd;
        logic        oa;
        logic        e_req, e_alw, e_ov;
        logic        bp;    // response visible same cycle when bypass is built in
        logic [31:0] e_pc, e_inst;
        logic [2:0]  e_qc;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;
    int   accepted;

    task automatic v(input logic iv, input logic [31:0] pc, input logic [4:0] blk,
                     input logic fl, input logic aok, input logic dok, input logic [31:0] rd,
                     input logic oa, input logic e_req, input logic e_alw, input logic e_ov,
                     input logic bp, input logic [31:0] e_pc, input logic [31:0] e_inst,
                     input logic [2:0] e_qc);
        vec_t r;
        r.iv = iv; r.pc = pc; r.blk = blk; r.fl = fl; r.aok = aok; r.dok = dok; r.rd = rd;
        r.oa = oa; r.e_req = e_req; r.e_alw = e_alw; r.e_ov = e_ov; r.bp = bp;
        r.e_pc = e_pc; r.e_inst = e_inst; r.e_qc = e_qc;
        vecs.push_back(r);
    endtask

    task automatic setin(input logic iv, input logic [31:0] pc, input logic [4:0] blk,
                         input logic fl, input logic aok, input logic dok,
                         input logic [31:0] rd, input logic oa);
        in_valid = iv; in_pc = pc; block_vec = blk; flush = fl;
        inst_sram_addr_ok = aok; inst_sram_data_ok = dok; inst_sram_rdata = rd;
        out_allowin = oa;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        setin(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        setin(0, 0, 0, 0, 0, 0, 0, 0);

        // reset state
        v(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        // single fetch
        v(1, 32'hBFC00000, 0, 0, 0, 0, 0, 0,             1, 1'b0, 0, 0, 0, 0, 0);
        v(1, 32'hBFC00000, 0, 0, 1, 0, 0, 0,             1, 1, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 1, 32'h24080001, 0,             0, 0, 0, 1, 32'hBFC00000, 32'h24080001, 0);
        v(0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 1, 0, 32'hBFC00000, 32'h24080001, 1);
        v(0, 0, 0, 0, 0, 0, 0, 1,                        0, 0, 1, 0, 32'hBFC00000, 32'h24080001, 1);
        v(0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 0);
        // credit limit: four accepted, fifth held off until a pop
        v(1, 32'h1000, 0, 0, 1, 0, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
        v(1, 32'h1004, 0, 0, 1, 0, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
        v(1, 32'h1008, 0, 0, 1, 0, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
        v(1, 32'h100C, 0, 0, 1, 0, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
        v(1, 32'h1010, 0, 0, 1, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0);
        v(1, 32'h1010, 0, 0, 1, 1, 32'h11110000, 0,      0, 0, 0, 1, 32'h1000, 32'h11110000, 0);
        v(1, 32'h1010, 0, 0, 1, 1, 32'h22220001, 0,      0, 0, 1, 0, 32'h1000, 32'h11110000, 1);
        v(1, 32'h1010, 0, 0, 1, 1, 32'h33330002, 0,      0, 0, 1, 0, 32'h1000, 32'h11110000, 2);
        v(1, 32'h1010, 0, 0, 1, 1, 32'h44440003, 0,      0, 0, 1, 0, 32'h1000, 32'h11110000, 3);
        v(1, 32'h1010, 0, 0, 1, 0, 0, 1,                 0, 0, 1, 0, 32'h1000, 32'h11110000, 4);
        v(1, 32'h1010, 0, 0, 1, 0, 0, 0,                 1, 1, 1, 0, 32'h1004, 32'h22220001, 3);
        v(0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 1, 0, 32'h1004, 32'h22220001, 3);
        v(0, 0, 0, 0, 0, 0, 0, 1,                        0, 0, 1, 0, 32'h1004, 32'h22220001, 3);
        v(0, 0, 0, 0, 0, 0, 0, 1,                        0, 0, 1, 0, 32'h1008, 32'h33330002, 2);
        // flush with 3 outstanding and 1 buffered
        v(1, 32'h1020, 0, 0, 1, 0, 0, 0,                 1, 1, 1, 0, 32'h100C, 32'h44440003, 1);
        v(1, 32'h1024, 0, 0, 1, 0, 0, 0,                 1, 1, 1, 0, 32'h100C, 32'h44440003, 1);
        v(1, 32'h1028, 0, 1, 1, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 1);
        v(0, 0, 0, 0, 0, 1, 32'hDEAD0000, 0,             0, 0, 0, 0, 0, 0, 0);
        v(1, 32'hBFC00380, 0, 0, 1, 1, 32'hDEAD0001, 0,  1, 1, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 1, 32'hDEAD0002, 0,             0, 0, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 1, 32'h3C1DBFC0, 0,             0, 0, 0, 1, 32'hBFC00380, 32'h3C1DBFC0, 0);
        v(0, 0, 0, 0, 0, 0, 0, 1,                        0, 0, 1, 0, 32'hBFC00380, 32'h3C1DBFC0, 1);
        v(0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 0);
        // flush coinciding with data_ok, 2 outstanding
        v(1, 32'h2000, 0, 0, 1, 0, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
        v(1, 32'h2004, 0, 0, 1, 0, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
        v(1, 32'h2008, 0, 1, 1, 1, 32'hEEEE0000, 0,      0, 0, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 1, 32'hEEEE0001, 0,             0, 0, 0, 0, 0, 0, 0);
        v(1, 32'h2008, 0, 0, 1, 0, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 1, 32'hEEEE0002, 0,             0, 0, 0, 1, 32'h2008, 32'hEEEE0002, 0);
        v(0, 0, 0, 0, 0, 0, 0, 1,                        0, 0, 1, 0, 32'h2008, 32'hEEEE0002, 1);
        v(0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 0);
        // block with 2 buffered entries
        v(1, 32'h3000, 0, 0, 1, 0, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
        v(1, 32'h3004, 0, 0, 1, 0, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 1, 32'hF0F00000, 0,             0, 0, 0, 1, 32'h3000, 32'hF0F00000, 0);
        v(0, 0, 0, 0, 0, 1, 32'hF0F00001, 0,             0, 0, 1, 0, 32'h3000, 32'hF0F00000, 1);
        v(1, 32'h3008, 5'b00100, 0, 1, 0, 0, 1,          0, 0, 0, 0, 0, 0, 2);
        v(1, 32'h3008, 5'b00100, 0, 1, 0, 0, 1,          0, 0, 0, 0, 0, 0, 2);
        v(0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 1, 0, 32'h3000, 32'hF0F00000, 2);
        v(0, 0, 0, 0, 0, 0, 0, 1,                        0, 0, 1, 0, 32'h3000, 32'hF0F00000, 2);
        v(0, 0, 0, 0, 0, 0, 0, 1,                        0, 0, 1, 0, 32'h3004, 32'hF0F00001, 1);
        v(0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 0);
        // push and pop together at q_count=DEPTH-1
        v(1, 32'h4000, 0, 0, 1, 0, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
        v(1, 32'h4004, 0, 0, 1, 0, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
        v(1, 32'h4008, 0, 0, 1, 0, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
        v(1, 32'h400C, 0, 0, 1, 0, 0, 0,                 1, 1, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 1, 32'h60000000, 0,             0, 0, 0, 1, 32'h4000, 32'h60000000, 0);
        v(0, 0, 0, 0, 0, 1, 32'h60000001, 0,             0, 0, 1, 0, 32'h4000, 32'h60000000, 1);
        v(0, 0, 0, 0, 0, 1, 32'h60000002, 0,             0, 0, 1, 0, 32'h4000, 32'h60000000, 2);
        v(0, 0, 0, 0, 0, 1, 32'h60000003, 1,             0, 0, 1, 0, 32'h4000, 32'h60000000, 3);
        v(0, 0, 0, 0, 0, 0, 0, 1,                        0, 0, 1, 0, 32'h4004, 32'h60000001, 3);
        v(0, 0, 0, 0, 0, 0, 0, 1,                        0, 0, 1, 0, 32'h4008, 32'h60000002, 2);
        v(0, 0, 0, 0, 0, 0, 0, 1,                        0, 0, 1, 0, 32'h400C, 32'h60000003, 1);
        v(0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            logic exp_ov;
            @(negedge clk);
            setin(vecs[i].iv, vecs[i].pc, vecs[i].blk, vecs[i].fl, vecs[i].aok,
                  vecs[i].dok, vecs[i].rd, vecs[i].oa);
            #1;
            exp_ov = vecs[i].e_ov | (BYP & vecs[i].bp);
            check($sformatf("vec%0d req/allowin/out_valid/q_count", i),
                  {58'd0, inst_sram_req, in_allowin, out_valid, q_count},
                  {58'd0, vecs[i].e_req, vecs[i].e_alw, exp_ov, vecs[i].e_qc});
            if (exp_ov) begin
                check($sformatf("vec%0d out_pc/out_inst", i), {out_pc, out_inst},
                      {vecs[i].e_pc, vecs[i].e_inst});
            end
            if (vecs[i].iv) begin
                check($sformatf("vec%0d sram_addr", i), {32'd0, inst_sram_addr},
                      {32'd0, vecs[i].pc});
            end
        end

        // mid-operation reset clears pending count and queue
        @(negedge clk); setin(1, 32'h5000, 0, 0, 1, 0, 0, 0);
        @(negedge clk); setin(1, 32'h5004, 0, 0, 1, 0, 0, 0);
        @(negedge clk); setin(0, 0, 0, 0, 0, 1, 32'h77770000, 0);
        @(negedge clk); setin(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("pre-reset q_count", {61'd0, q_count}, 64'd1);
        do_reset();
        #1;
        check("post-reset q_count/out_valid/req", {59'd0, q_count, out_valid, inst_sram_req}, 64'd0);
        accepted = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            setin(1, 32'h5100 + 32'(c * 4), 0, 0, 1, 0, 0, 0);
            #1;
            if (in_allowin) accepted++;
        end
        check("post-reset accepted count", 64'(accepted), 64'd4);

`ifdef IFQ_BYPASS_EN
        do_reset();
        @(negedge clk); setin(1, 32'h6000, 0, 0, 1, 0, 0, 0);
        @(negedge clk); setin(0, 0, 0, 0, 0, 1, 32'h00000000, 1);
        #1;
        check("bypass same-cycle out", {31'd0, out_valid, out_pc}, {31'd0, 1'b1, 32'h6000});
        check("bypass inst", {32'd0, out_inst}, 64'd0);
        @(negedge clk); setin(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("bypass q_count/out_valid", {60'd0, q_count, out_valid}, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
